// File: rtl/dft_mac_sequencer.sv
// Control sequencer for the MAC-mode DFT datapath: sample load handshake, RAM->cache copy,
// n/k MAC loops with an incremental twiddle index, accumulator gating and result write-back.
module dft_mac_sequencer #(
  parameter int ADDR_W   = 12,
  parameter int MAX_N    = 4096,
  parameter int PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [ADDR_W-1:0] samp_num,
  input  logic              data_loaded,
  output logic              load_nCompute,
  output logic [ADDR_W-1:0] ram_rd_adr,
  output logic              cache_wr,
  output logic [ADDR_W-1:0] cache_wr_adr,
  output logic [ADDR_W-1:0] cache_rd_adr,
  output logic [ADDR_W-1:0] tw_idx,
  output logic              acc_ce,
  output logic              acc_clr,
  output logic              res_wr,
  output logic [ADDR_W-1:0] res_adr,
  output logic              busy,
  output logic              calc_end,
  output logic              cfg_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_COPY    = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [2:0] S_WRITE   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [ADDR_W:0]   MAX_N_W    = (ADDR_W+1)'(MAX_N);
  localparam logic [ADDR_W:0]   MIN_N_W    = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0]   DRAIN_LAST = (ADDR_W+1)'(PIPE_LAT);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE    = ADDR_W'(1);

  logic [2:0]        state_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] n_q;
  logic [ADDR_W-1:0] k_q;
  logic [ADDR_W-1:0] tw_q;
  logic [ADDR_W:0]   cnt_q;
  logic              cache_wr_q;
  logic [ADDR_W-1:0] cache_wr_adr_q;
  logic              cfg_err_q;
  logic [PIPE_LAT:0] vld_q;
  logic [PIPE_LAT:0] first_q;

  logic              samp_ok;
  logic              issue;
  logic              last_n;
  logic              last_k;
  logic              copy_rd;
  logic [ADDR_W:0]   tw_sum;
  logic [ADDR_W:0]   tw_wrap;
  logic [ADDR_W-1:0] tw_next;

  assign samp_ok = ({1'b0, samp_num} >= MIN_N_W) && ({1'b0, samp_num} <= MAX_N_W);
  assign issue   = (state_q == S_COMPUTE);
  assign last_n  = (n_q == len_q - IDX_ONE);
  assign last_k  = (k_q == len_q - IDX_ONE);
  assign copy_rd = (state_q == S_COPY) && (cnt_q < {1'b0, len_q});

  // (n*k) mod N tracked by repeated addition; tw and k are both < N so one subtract suffices
  always_comb begin
    tw_sum  = {1'b0, tw_q} + {1'b0, k_q};
    tw_wrap = tw_sum;
    if (tw_sum >= {1'b0, len_q}) tw_wrap = tw_sum - {1'b0, len_q};
    tw_next = tw_wrap[ADDR_W-1:0];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q        <= S_IDLE;
      len_q          <= '0;
      n_q            <= '0;
      k_q            <= '0;
      tw_q           <= '0;
      cnt_q          <= '0;
      cache_wr_q     <= 1'b0;
      cache_wr_adr_q <= '0;
      cfg_err_q      <= 1'b0;
      vld_q          <= '0;
      first_q        <= '0;
    end else begin
      cfg_err_q      <= 1'b0;
      cache_wr_q     <= 1'b0;
      cache_wr_adr_q <= '0;

      // issue tracker: each COMPUTE cycle reaches the accumulator PIPE_LAT+1 cycles later
      for (int i = PIPE_LAT; i > 0; i--) begin
        vld_q[i]   <= vld_q[i-1];
        first_q[i] <= first_q[i-1];
      end
      vld_q[0]   <= issue;
      first_q[0] <= issue && (n_q == '0);

      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (samp_ok) begin
              len_q   <= samp_num;
              state_q <= S_LOAD;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (data_loaded) begin
            cnt_q   <= '0;
            state_q <= S_COPY;
          end
        end
        S_COPY: begin
          // RAM read latency of one cycle: the write trails the read address
          if (copy_rd) begin
            cache_wr_q     <= 1'b1;
            cache_wr_adr_q <= cnt_q[ADDR_W-1:0];
            cnt_q          <= cnt_q + CNT_ONE;
          end else begin
            n_q     <= '0;
            k_q     <= '0;
            tw_q    <= '0;
            cnt_q   <= '0;
            state_q <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          if (last_n) begin
            cnt_q   <= '0;
            state_q <= S_DRAIN;
          end else begin
            n_q  <= n_q + IDX_ONE;
            tw_q <= tw_next;
          end
        end
        S_DRAIN: begin
          if (cnt_q == DRAIN_LAST) state_q <= S_WRITE;
          else                     cnt_q   <= cnt_q + CNT_ONE;
        end
        S_WRITE: begin
          if (last_k) begin
            state_q <= S_DONE;
          end else begin
            k_q     <= k_q + IDX_ONE;
            n_q     <= '0;
            tw_q    <= '0;
            state_q <= S_COMPUTE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign load_nCompute = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_COPY);
  assign ram_rd_adr    = copy_rd ? cnt_q[ADDR_W-1:0] : '0;
  assign cache_wr      = cache_wr_q;
  assign cache_wr_adr  = cache_wr_adr_q;
  assign cache_rd_adr  = issue ? n_q : '0;
  assign tw_idx        = issue ? tw_q : '0;
  assign acc_ce        = vld_q[PIPE_LAT];
  assign acc_clr       = vld_q[PIPE_LAT] & first_q[PIPE_LAT];
  assign res_wr        = (state_q == S_WRITE);
  assign res_adr       = res_wr ? k_q : '0;
  assign calc_end      = (state_q == S_DONE);
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_dft_mac_sequencer.sv
// Bench for dft_mac_sequencer: random transform sizes checked cycle by cycle against
// an offset-based timeline model with direct (n*k) mod N twiddle arithmetic.
module tb_dft_mac_sequencer;

  localparam int ADDR_W   = 4;
  localparam int MAX_N    = 8;
  localparam int PIPE_LAT = 2;

  logic              clk = 1'b0;
  logic              nrst;
  logic              start;
  logic [ADDR_W-1:0] samp_num;
  logic              data_loaded;
  logic              load_nCompute;
  logic [ADDR_W-1:0] ram_rd_adr;
  logic              cache_wr;
  logic [ADDR_W-1:0] cache_wr_adr;
  logic [ADDR_W-1:0] cache_rd_adr;
  logic [ADDR_W-1:0] tw_idx;
  logic              acc_ce;
  logic              acc_clr;
  logic              res_wr;
  logic [ADDR_W-1:0] res_adr;
  logic              busy;
  logic              calc_end;
  logic              cfg_err;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cur_n   = 0;
  int ce_seen = 0;

  dft_mac_sequencer #(
    .ADDR_W  (ADDR_W),
    .MAX_N   (MAX_N),
    .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .start        (start),
    .samp_num     (samp_num),
    .data_loaded  (data_loaded),
    .load_nCompute(load_nCompute),
    .ram_rd_adr   (ram_rd_adr),
    .cache_wr     (cache_wr),
    .cache_wr_adr (cache_wr_adr),
    .cache_rd_adr (cache_rd_adr),
    .tw_idx       (tw_idx),
    .acc_ce       (acc_ce),
    .acc_clr      (acc_clr),
    .res_wr       (res_wr),
    .res_adr      (res_adr),
    .busy         (busy),
    .calc_end     (calc_end),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_rst_outputs(input string tag);
    chk({tag, ".load_nCompute"}, 32'(load_nCompute), 1);
    chk({tag, ".busy"},          32'(busy), 0);
    chk({tag, ".acc_ce"},        32'(acc_ce), 0);
    chk({tag, ".acc_clr"},       32'(acc_clr), 0);
    chk({tag, ".res_wr"},        32'(res_wr), 0);
    chk({tag, ".res_adr"},       32'(res_adr), 0);
    chk({tag, ".calc_end"},      32'(calc_end), 0);
    chk({tag, ".cfg_err"},       32'(cfg_err), 0);
    chk({tag, ".cache_wr"},      32'(cache_wr), 0);
    chk({tag, ".cache_wr_adr"},  32'(cache_wr_adr), 0);
    chk({tag, ".cache_rd_adr"},  32'(cache_rd_adr), 0);
    chk({tag, ".tw_idx"},        32'(tw_idx), 0);
    chk({tag, ".ram_rd_adr"},    32'(ram_rd_adr), 0);
  endtask

  // Independent accumulator-gating monitor: N enables per bin, clear only alongside an enable
  always @(negedge nrst) ce_seen = 0;
  always @(negedge clk) begin
    if (nrst) begin
      chk("clr_without_ce", 32'(acc_clr & ~acc_ce), 0);
      if (res_wr) begin
        chk("ce_per_bin", 32'(ce_seen), 32'(cur_n));
        ce_seen = 0;
      end
      if (acc_ce) ce_seen++;
    end
  end

  task automatic cfg_err_case(input int v);
    start    = 1'b1;
    samp_num = ADDR_W'(v);
    @(negedge clk);
    start = 1'b0;
    chk("cfg_err_pulse", 32'(cfg_err), 1);
    chk("cfg_err_busy",  32'(busy), 0);
    @(negedge clk);
    chk("cfg_err_end",   32'(cfg_err), 0);
    chk("cfg_err_busy2", 32'(busy), 0);
  endtask

  // Entered and left at a negedge with the DUT idle (unless aborted via abort_k)
  task automatic run_xform(input int n, input int abort_k, input bit poke);
    int d;
    d        = $urandom_range(0, 3);
    cur_n    = n;
    start    = 1'b1;
    samp_num = ADDR_W'(n);
    data_loaded = (d == 0);
    @(negedge clk);
    start = 1'b0;
    chk("load_busy", 32'(busy), 1);
    chk("load_lnc",  32'(load_nCompute), 1);
    if (d > 0) begin
      repeat (d - 1) begin
        @(negedge clk);
        chk("load_wait_cache_wr", 32'(cache_wr), 0);
      end
      data_loaded = 1'b1;
    end
    @(negedge clk);
    data_loaded = 1'b0;

    for (int i = 0; i <= n; i++) begin
      chk("copy_lnc",      32'(load_nCompute), 1);
      chk("copy_cache_wr", 32'(cache_wr), 32'(i >= 1));
      if (i >= 1) chk("copy_wr_adr", 32'(cache_wr_adr), 32'(i - 1));
      if (i < n)  chk("copy_rd_adr", 32'(ram_rd_adr), 32'(i));
      chk("copy_acc_ce",   32'(acc_ce), 0);
      @(negedge clk);
    end

    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < n + PIPE_LAT + 2; c++) begin
        chk("cmp_lnc",      32'(load_nCompute), 0);
        chk("cmp_busy",     32'(busy), 1);
        chk("cmp_calc_end", 32'(calc_end), 0);
        if (c < n) begin
          chk("cmp_rd_adr", 32'(cache_rd_adr), 32'(c));
          chk("cmp_tw_idx", 32'(tw_idx), 32'((c * k) % n));
        end
        chk("cmp_acc_ce",  32'(acc_ce),  32'((c >= PIPE_LAT + 1) && (c <= n + PIPE_LAT)));
        chk("cmp_acc_clr", 32'(acc_clr), 32'(c == PIPE_LAT + 1));
        chk("cmp_res_wr",  32'(res_wr),  32'(c == n + PIPE_LAT + 1));
        if (c == n + PIPE_LAT + 1) chk("cmp_res_adr", 32'(res_adr), 32'(k));
        if (abort_k == k && c == n + 1) begin
          nrst = 1'b0;
          #1;
          chk_rst_outputs("abort");
          @(negedge clk);
          nrst = 1'b1;
          return;
        end
        if (poke && k == 1 && c == 2) begin
          start    = 1'b1;
          samp_num = ADDR_W'((n == MAX_N) ? 3 : MAX_N);
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk("done_calc_end", 32'(calc_end), 1);
    chk("done_busy",     32'(busy), 1);
    chk("done_res_wr",   32'(res_wr), 0);
    @(negedge clk);
    chk("post_calc_end", 32'(calc_end), 0);
    chk("post_busy",     32'(busy), 0);
    chk("post_lnc",      32'(load_nCompute), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    nrst        = 1'b0;
    start       = 1'b0;
    samp_num    = '0;
    data_loaded = 1'b0;
    #2;
    chk_rst_outputs("por");
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk_rst_outputs("idle_after_rst");

    run_xform(4, -1, 1'b0);
    run_xform(5, -1, 1'b0);

    cfg_err_case(1);
    cfg_err_case(MAX_N + 1);
    cfg_err_case(0);

    run_xform(2, -1, 1'b0);
    run_xform(MAX_N, -1, 1'b1);
    run_xform(4, -1, 1'b1);

    run_xform(6, 2, 1'b0);
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_res_wr",   32'(res_wr), 0);
      chk("abort_no_calc_end", 32'(calc_end), 0);
      chk("abort_idle",        32'(busy), 0);
    end
    run_xform(4, -1, 1'b0);

    repeat (5) run_xform($urandom_range(2, MAX_N), -1, 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
